// File: rtl/bram_pkg.sv
// Shared types and helpers for the block-RAM buffer family.
package bram_pkg;

  typedef enum logic {READ_FIRST = 1'b0, WRITE_FIRST = 1'b1} rd_mode_e;

  typedef enum logic {CLR_IDLE = 1'b0, CLR_CLEARING = 1'b1} clr_state_e;

  localparam int unsigned LM_MAX_BITS = 1024;

  typedef logic [LM_MAX_BITS-1:0] lm_word_t;

  // Lane-wise merge: new lanes where lane_en is set, old lanes elsewhere.
  // Callers widen into lm_word_t and truncate the result back to their width.
  function automatic lm_word_t lane_merge(input lm_word_t old_w, input lm_word_t new_w,
                                          input lm_word_t lane_en, input int unsigned lane_bits);
    lm_word_t merged;
    merged = old_w;
    for (int unsigned i = 0; i < LM_MAX_BITS; i++) begin
      if (lane_en[i / lane_bits]) merged[i] = new_w[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Clear sweep sequencer: walks every address once after reset or a clear request.
module bram_clear_seq
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] sweep_addr,
  output logic                 sweep_we
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  clr_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_CLEARING: begin
        cnt_d = cnt_q + ADDR_BITS'(1);
        if (cnt_q == LAST_ADDR) state_d = CLR_IDLE;
      end
      CLR_IDLE: begin
        if (clear) begin
          state_d = CLR_CLEARING;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == CLR_CLEARING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_CLEARING;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign sweep_we   = busy_q;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/bram_rw.sv
// Simple-dual-port block RAM with lane write enables, selectable collision mode,
// optional output register and a hardware clear sweep.
module bram_rw
  import bram_pkg::*;
#(
  parameter int unsigned          ADDR_BITS   = 8,
  parameter int unsigned          DATA_BITS   = 64,
  parameter int unsigned          LANE_BITS   = 8,
  parameter rd_mode_e             RD_MODE     = READ_FIRST,
  parameter bit                   OUT_REG     = 1'b0,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0,
  localparam int unsigned         LANES       = DATA_BITS / LANE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 wr_en,
  input  logic [LANES-1:0]     wr_lane_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [ADDR_BITS-1:0] sweep_addr;
  logic                 sweep_we;

  bram_clear_seq #(.ADDR_BITS(ADDR_BITS)) u_clear_seq (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (clear),
    .busy       (busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 rd_grant_c, wr_grant_c, mem_we_c;
  logic [ADDR_BITS-1:0] mem_waddr_c;
  logic [DATA_BITS-1:0] mem_wdata_c, rd_word_c;
  logic [LANES-1:0]     mem_lane_c;

  // Clear request outranks same-cycle reads and writes; the sweep owns the write port.
  always_comb begin
    rd_grant_c  = rd_en && !busy && !clear;
    wr_grant_c  = wr_en && !busy && !clear;
    mem_we_c    = sweep_we || wr_grant_c;
    mem_waddr_c = sweep_we ? sweep_addr : wr_addr;
    mem_wdata_c = sweep_we ? CLEAR_VALUE : wr_data;
    mem_lane_c  = sweep_we ? '1 : wr_lane_en;
    rd_word_c   = mem[rd_addr];
    if (RD_MODE == WRITE_FIRST && wr_grant_c && wr_addr == rd_addr) begin
      rd_word_c = DATA_BITS'(lane_merge(LM_MAX_BITS'(mem[rd_addr]), LM_MAX_BITS'(wr_data),
                                        LM_MAX_BITS'(wr_lane_en), LANE_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mem_lane_c[i]) mem[mem_waddr_c][i*LANE_BITS +: LANE_BITS] <= mem_wdata_c[i*LANE_BITS +: LANE_BITS];
      end
    end
  end

  logic                 s1_valid_q, s1_valid_d, rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] s1_data_q, s1_data_d, rd_data_q, rd_data_d;

  // Read pipeline; data registers only load when a read completes.
  always_comb begin
    s1_valid_d = rd_grant_c;
    s1_data_d  = rd_grant_c ? rd_word_c : s1_data_q;
    if (OUT_REG) begin
      rd_valid_d = s1_valid_q;
      rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
    end else begin
      rd_valid_d = rd_grant_c;
      rd_data_d  = rd_grant_c ? rd_word_c : rd_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/bram_rw.md
# bram_rw

Parametrised simple-dual-port block RAM, the successor of the plotter's basic BRAM buffer. It adds byte-lane write enables, a selectable read-during-write mode, an optional output register, and a read-valid handshake. Its clear is a sequential sweep that maps onto real FPGA block RAM, replacing the non-synthesisable single-cycle wipe. It serves as the shared storage primitive for command and motion buffers.

## Interface
- ADDR_BITS, 8, address width; depth = 2**ADDR_BITS words.
- DATA_BITS, 64, word width; must be a multiple of LANE_BITS.
- LANE_BITS, 8, bits per write-enable lane; LANES = DATA_BITS/LANE_BITS.
- RD_MODE, READ_FIRST, read-during-write same-address behaviour (READ_FIRST or WRITE_FIRST).
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- CLEAR_VALUE, 0, word written at every address by a clear sweep.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  pulse; starts a clear sweep when idle.
- busy  out  1  high while a clear sweep runs.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  DATA_BITS  read word.
- rd_valid  out  1  rd_data holds the result of a granted read.
- wr_en  in  1  write request.
- wr_lane_en  in  LANES  per-lane write enable; lane i = bits [i*LANE_BITS +: LANE_BITS].
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_BITS  write word.

## Operation
- Two states: CLEARING and IDLE.
- Reset asserted: the block enters CLEARING with the sweep counter at 0. busy=1, rd_valid=0, rd_data=0. Memory contents are not reset.
- CLEARING: each cycle, the word at the sweep counter is set to CLEAR_VALUE and the counter increments. After address 2**ADDR_BITS-1 is written, the block moves to IDLE and busy drops the next cycle. A sweep takes exactly 2**ADDR_BITS cycles.
- During CLEARING:
  - wr_en and rd_en are ignored; no grant and no rd_valid.
  - clear is ignored; the sweep does not restart.
  - Reads already in the output pipeline when the sweep starts still complete with their sampled data.
- IDLE:
  - clear=1 enters CLEARING next edge with the counter at 0; busy=1 from that edge. clear takes priority over a same-cycle rd_en or wr_en, and both are dropped.
  - wr_en=1 updates only the lanes whose wr_lane_en bit is 1. wr_lane_en=0 leaves the word unchanged.
  - rd_en=1 is a granted read.
- Same-address read and write in the same cycle:
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the lane-merged new word (old lanes where the enable is 0).
- Different addresses are independent. Back-to-back reads at one per cycle are sustained.
- rd_data holds its last value when no read completes. rd_valid is a single-cycle pulse per granted read.

## Timing
- Read latency: a read granted at edge N gives rd_data and rd_valid at N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
- Write becomes visible to a read granted at the edge after the write edge, regardless of RD_MODE.
- busy rises on the edge after clear is sampled, or immediately on reset assertion.
- Reset mid-sweep or mid-read: the sweep restarts from 0 and in-flight reads are discarded (rd_valid=0).

## Structure
- Package bram_pkg holds:
  - enum rd_mode_e {READ_FIRST, WRITE_FIRST}.
  - Function lane_merge(old, new, lane_en) shared with other buffers.
- Sub-module bram_clear_seq holds the sweep counter and the CLEARING/IDLE state. Its outputs are busy, the sweep address and the sweep write strobe.
- The array stays a plain reg array with one write port and one read port, so it infers block RAM.

## Test plan
- Bench configuration: ADDR_BITS=4, DATA_BITS=16, LANE_BITS=8.
- Reset release: busy=1 for exactly 16 cycles. Then read addresses 0..15 back-to-back; every rd_data=0x0000 and rd_valid is high for 16 consecutive cycles, one cycle after each request.
- Lane write: write 0xABCD to address 3 with lanes 11, then 0x1200 with lanes 10. Reading address 3 -> 0x12CD.
- Same-cycle collision:
  - Address 5 holds 0x1111; write 0x2222 and read address 5 in the same cycle.
  - READ_FIRST -> 0x1111. WRITE_FIRST -> 0x2222.
  - In both modes the next read -> 0x2222.
- OUT_REG=1: read issued at edge N -> rd_valid at N+2 only. Three back-to-back reads -> three consecutive valid cycles.
- Clear priority:
  - In IDLE, assert clear together with a write of 0xFFFF to address 7 -> the write is dropped.
  - rd_en during the sweep -> no rd_valid.
  - After the 16-cycle sweep, address 7 reads 0x0000.
- Reset during a sweep at counter 9: busy stays 1. After release the sweep restarts at 0 and busy stays high 16 more cycles. An in-flight read gives no rd_valid.
